// File: rtl/mesi_tag_ctrl_pkg.sv
// Shared types and default widths for the MESI tag-array controller.
// The state encoding is chosen so that a zero-initialised array reads as all-Invalid.
package mesi_pkg;

  localparam int ADDR_W = 32;
  localparam int IDX_W  = 10;
  localparam int TAG_W  = 20;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_e;

  typedef enum logic [1:0] {
    BUS_NONE = 2'b00,
    BUS_RD   = 2'b01,
    BUS_RDX  = 2'b10,
    BUS_UPGR = 2'b11
  } bus_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_LOOKUP   = 2'b01,
    ST_UPDATE   = 2'b10,
    ST_BUS_WAIT = 2'b11
  } fsm_e;

endpackage

// File: rtl/mesi_tag_ctrl_if.sv
// CPU, snoop, coherence-bus and tag-array signals of the controller.
// The slave modport is the controller; master is the surrounding core/bus/array.
interface mesi_tag_ctrl_if
  import mesi_pkg::*;
#(
  parameter int A_W = ADDR_W,
  parameter int I_W = IDX_W,
  parameter int T_W = TAG_W
);
  logic           cpu_req_valid;
  logic           cpu_req_ready;
  logic [A_W-1:0] cpu_req_addr;
  logic           cpu_req_wr;
  logic           cpu_rsp_valid;
  logic           cpu_rsp_hit;

  logic           snp_valid;
  logic           snp_ready;
  logic [A_W-1:0] snp_addr;
  logic           snp_rdx;
  logic           snp_rsp_valid;
  logic           snp_rsp_hit;
  logic           snp_rsp_flush;

  logic           bus_req_valid;
  logic [1:0]     bus_req_op;
  logic [A_W-1:0] bus_req_addr;
  logic           bus_req_wb;
  logic           bus_done;
  logic           bus_shared;

  logic [I_W-1:0] ta_index;
  logic [T_W-1:0] ta_tag_in;
  logic [1:0]     ta_state_in;
  logic           ta_write_en;
  logic [T_W-1:0] ta_tag_out;
  logic [1:0]     ta_state_out;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_req_wr,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit,
    input  snp_valid, snp_addr, snp_rdx,
    output snp_ready, snp_rsp_valid, snp_rsp_hit, snp_rsp_flush,
    output bus_req_valid, bus_req_op, bus_req_addr, bus_req_wb,
    input  bus_done, bus_shared,
    output ta_index, ta_tag_in, ta_state_in, ta_write_en,
    input  ta_tag_out, ta_state_out
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_req_wr,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_hit,
    output snp_valid, snp_addr, snp_rdx,
    input  snp_ready, snp_rsp_valid, snp_rsp_hit, snp_rsp_flush,
    input  bus_req_valid, bus_req_op, bus_req_addr, bus_req_wb,
    output bus_done, bus_shared,
    input  ta_index, ta_tag_in, ta_state_in, ta_write_en,
    output ta_tag_out, ta_state_out
  );
endinterface

// File: rtl/mesi_tag_ctrl_next_state.sv
// Pure MESI transition table: given the looked-up line and the request kind,
// decide the new state, whether the array must be written, the bus op and flush.
module mesi_next_state
  import mesi_pkg::*;
(
  input  mesi_e   old_state,
  input  logic    is_snoop,
  input  logic    is_write,
  input  logic    hit,
  input  logic    bus_shared,
  output mesi_e   new_state,
  output logic    write_needed,
  output bus_op_e bus_op,
  output logic    flush
);

  always_comb begin
    new_state    = old_state;
    write_needed = 1'b0;
    bus_op       = BUS_NONE;
    flush        = 1'b0;
    if (is_snoop) begin
      if (hit) begin
        flush = (old_state == MESI_M);
        if (is_write) begin
          new_state    = MESI_I;
          write_needed = 1'b1;
        end else begin
          new_state    = MESI_S;
          write_needed = (old_state != MESI_S);
        end
      end
    end else if (hit) begin
      if (is_write) begin
        case (old_state)
          MESI_E: begin
            new_state    = MESI_M;
            write_needed = 1'b1;
          end
          MESI_S: begin
            new_state    = MESI_M;
            write_needed = 1'b1;
            bus_op       = BUS_UPGR;
          end
          default: ;
        endcase
      end
    end else begin
      write_needed = 1'b1;
      if (is_write) begin
        new_state = MESI_M;
        bus_op    = BUS_RDX;
      end else begin
        // Final S/E choice is re-evaluated with bus_shared when the fill completes.
        new_state = bus_shared ? MESI_S : MESI_E;
        bus_op    = BUS_RD;
      end
    end
  end

endmodule

// File: rtl/mesi_tag_ctrl.sv
// Sequencing FSM for the MESI tag array: arbitrates CPU and snoop requests,
// looks up the line, issues bus transactions and writes back tag/state.
module mesi_tag_ctrl
  import mesi_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mesi_tag_ctrl_if.slave  io
);

  fsm_e              state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              snoop_q, snoop_d;
  logic              wr_q, wr_d;
  logic              hit_q, hit_d;
  logic              wb_q, wb_d;
  logic              write_q, write_d;
  logic              flush_q, flush_d;
  mesi_e             old_q, old_d;
  mesi_e             new_q, new_d;
  bus_op_e           op_q, op_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit_now;
  mesi_e             ns_old;
  logic              ns_hit;
  mesi_e             ns_new;
  logic              ns_write;
  bus_op_e           ns_op;
  logic              ns_flush;

  assign idx     = addr_q[IDX_W+1:2];
  assign tag     = addr_q[ADDR_W-1:IDX_W+2];
  assign hit_now = (io.ta_tag_out == tag) && (mesi_e'(io.ta_state_out) != MESI_I);

  // During LOOKUP the table sees the live array read; in BUS_WAIT it sees the
  // latched lookup so the fill state can pick up bus_shared at completion.
  assign ns_old = (state_q == ST_LOOKUP) ? mesi_e'(io.ta_state_out) : old_q;
  assign ns_hit = (state_q == ST_LOOKUP) ? hit_now : hit_q;

  mesi_next_state u_next_state (
    .old_state    (ns_old),
    .is_snoop     (snoop_q),
    .is_write     (wr_q),
    .hit          (ns_hit),
    .bus_shared   (io.bus_shared),
    .new_state    (ns_new),
    .write_needed (ns_write),
    .bus_op       (ns_op),
    .flush        (ns_flush)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    wr_d    = wr_q;
    hit_d   = hit_q;
    wb_d    = wb_q;
    write_d = write_q;
    flush_d = flush_q;
    old_d   = old_q;
    new_d   = new_q;
    op_d    = op_q;

    io.cpu_req_ready = 1'b0;
    io.cpu_rsp_valid = 1'b0;
    io.cpu_rsp_hit   = 1'b0;
    io.snp_ready     = 1'b0;
    io.snp_rsp_valid = 1'b0;
    io.snp_rsp_hit   = 1'b0;
    io.snp_rsp_flush = 1'b0;
    io.bus_req_valid = 1'b0;
    io.bus_req_op    = BUS_NONE;
    io.bus_req_addr  = '0;
    io.bus_req_wb    = 1'b0;
    io.ta_index      = '0;
    io.ta_tag_in     = '0;
    io.ta_state_in   = MESI_I;
    io.ta_write_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        io.snp_ready     = 1'b1;
        io.cpu_req_ready = !io.snp_valid;
        if (io.snp_valid) begin
          addr_d  = io.snp_addr;
          snoop_d = 1'b1;
          wr_d    = io.snp_rdx;
          state_d = ST_LOOKUP;
        end else if (io.cpu_req_valid) begin
          addr_d  = io.cpu_req_addr;
          snoop_d = 1'b0;
          wr_d    = io.cpu_req_wr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        io.ta_index = idx;
        io.ta_tag_in = tag;
        hit_d   = hit_now;
        old_d   = mesi_e'(io.ta_state_out);
        new_d   = ns_new;
        write_d = ns_write;
        flush_d = ns_flush;
        op_d    = ns_op;
        wb_d    = ((ns_op == BUS_RD) || (ns_op == BUS_RDX)) &&
                  (mesi_e'(io.ta_state_out) == MESI_M);
        state_d = (ns_op != BUS_NONE) ? ST_BUS_WAIT : ST_UPDATE;
      end
      ST_UPDATE: begin
        io.ta_index    = idx;
        io.ta_tag_in   = tag;
        io.ta_state_in = new_q;
        io.ta_write_en = write_q;
        if (snoop_q) begin
          io.snp_rsp_valid = 1'b1;
          io.snp_rsp_hit   = hit_q;
          io.snp_rsp_flush = flush_q;
        end else begin
          io.cpu_rsp_valid = 1'b1;
          io.cpu_rsp_hit   = hit_q;
        end
        state_d = ST_IDLE;
      end
      ST_BUS_WAIT: begin
        io.ta_index      = idx;
        io.ta_tag_in     = tag;
        io.bus_req_valid = 1'b1;
        io.bus_req_op    = op_q;
        io.bus_req_addr  = addr_q;
        io.bus_req_wb    = wb_q;
        if (io.bus_done) begin
          new_d   = ns_new;
          state_d = ST_UPDATE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      snoop_q <= 1'b0;
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      wb_q    <= 1'b0;
      write_q <= 1'b0;
      flush_q <= 1'b0;
      old_q   <= MESI_I;
      new_q   <= MESI_I;
      op_q    <= BUS_NONE;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      wr_q    <= wr_d;
      hit_q   <= hit_d;
      wb_q    <= wb_d;
      write_q <= write_d;
      flush_q <= flush_d;
      old_q   <= old_d;
      new_q   <= new_d;
      op_q    <= op_d;
    end
  end

endmodule

// File: doc/mesi_tag_ctrl.md
Name: mesi_tag_ctrl

Overview:
Sequencing controller for the per-cache MESI tag array (1024 entries, 20-bit tag, 2-bit state).
- Arbitrates between the local CPU request port and the incoming bus snoop port.
- Performs lookup, MESI next-state computation and tag/state write-back.
- Issues bus transactions (BusRd/BusRdX/BusUpgr) on misses and upgrades, and waits for completion.
- Sits between the core's load/store path, the tag array and the shared coherence bus.

Parameters:
ADDR_W, 32, byte address width
IDX_W, 10, tag-array index width
TAG_W, 20, tag width; ADDR_W = TAG_W + IDX_W + 2 (2-bit word offset)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cpu_req_valid  in  1  CPU request valid
cpu_req_ready  out  1  CPU request accepted when valid&ready
cpu_req_addr  in  ADDR_W  CPU address
cpu_req_wr  in  1  1=write, 0=read
cpu_rsp_valid  out  1  one-cycle response pulse
cpu_rsp_hit  out  1  line was present (state!=I) at lookup
snp_valid  in  1  snoop valid
snp_ready  out  1  snoop accepted when valid&ready
snp_addr  in  ADDR_W  snooped address
snp_rdx  in  1  1=BusRdX/BusUpgr, 0=BusRd
snp_rsp_valid  out  1  one-cycle snoop response pulse
snp_rsp_hit  out  1  line present
snp_rsp_flush  out  1  line was M; data must be supplied
bus_req_valid  out  1  held until bus_done
bus_req_op  out  2  00 none, 01 BUS_RD, 10 BUS_RDX, 11 BUS_UPGR
bus_req_addr  out  ADDR_W  registered request address
bus_req_wb  out  1  victim was M; write back before fill
bus_done  in  1  bus transaction complete
bus_shared  in  1  sampled with bus_done; another cache holds the line
ta_index  out  IDX_W  tag array index
ta_tag_in  out  TAG_W  tag to write
ta_state_in  out  2  state to write
ta_write_en  out  1  tag array write strobe
ta_tag_out  in  TAG_W  tag read (combinational)
ta_state_out  in  2  state read (combinational)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, port rst.
- State encoding: I=00, S=01, E=10, M=11. The zero-initialised array reads as all-Invalid.
- FSM states: IDLE, LOOKUP, UPDATE, BUS_WAIT.
- Ready and arbitration:
  - snp_ready = (state==IDLE).
  - cpu_req_ready = (state==IDLE) && !snp_valid. Snoop has strict priority.
  - The accepted address and operation are registered; ta_index is driven from the registered address in LOOKUP, UPDATE and BUS_WAIT.
- IDLE: on accept (cycle T), go to LOOKUP.
- LOOKUP (T+1):
  - hit = (ta_tag_out == tag) && ta_state_out != I.
  - Latch hit, old state and victim state.
  - Go to UPDATE, or to BUS_WAIT if a bus operation is needed.
- CPU read hit: no state change, ta_write_en=0.
- CPU write hit:
  - M stays M, no write.
  - E goes to M, written in UPDATE.
  - S issues BUS_UPGR; M is written after done.
- CPU read miss:
  - Issue BUS_RD; bus_req_wb = (victim==M).
  - On done, write new tag with state S if bus_shared, else E.
- CPU write miss: issue BUS_RDX with wb as above; on done, write tag with state M.
- Snoop (miss, or state I): no write; snp_rsp_hit=0, snp_rsp_flush=0.
- Snoop BusRd hit: M→S (flush=1); E→S; S stays S.
- Snoop BusRdX hit: any state→I; flush=1 iff the old state was M.
- UPDATE (T+2): at most one ta_write_en cycle, the response pulse, then IDLE.
- Latency:
  - No-bus operations respond at T+2.
  - Bus operations: bus_req_valid is asserted from T+2. If bus_done arrives at cycle D, ta_write_en and cpu_rsp_valid are asserted at D+1, then IDLE.
- Responses have no backpressure. cpu_rsp_hit reports the lookup result (1 for an S-upgrade).
- bus_done outside BUS_WAIT is ignored. Snoops are not accepted during BUS_WAIT; the bus guarantees completion without needing this cache's snoop response.
- Reset (including mid-operation):
  - Next state IDLE; the in-flight request is dropped.
  - All outputs 0 the cycle after rst is sampled, including bus_req_valid, ta_write_en and the rsp pulses.
  - Array contents are not touched.

Decomposition:
- Package mesi_pkg holds:
  - the MESI state encoding enum;
  - the bus_op enum;
  - the FSM state enum;
  - the ADDR_W/IDX_W/TAG_W defaults.
- One combinational sub-module, mesi_next_state, takes (old_state, is_snoop, is_write/rdx, hit, bus_shared) and returns (new_state, write_needed, bus_op, flush). The FSM stays in mesi_tag_ctrl.

Test Plan:
- After reset, CPU read 0x0000_1004 → LOOKUP miss; T+2 bus_req_op=BUS_RD, wb=0. bus_done with shared=0 → next cycle ta_write_en, index 0x001, tag 0x00001, state E; cpu_rsp hit=0.
- CPU write 0x0000_1004 → hit; at T+2 ta_write_en with state M; no bus_req_valid; cpu_rsp hit=1.
- Snoop BusRd 0x0000_1004 → snp_rsp hit=1, flush=1; state written S at T+2.
- CPU write 0x0000_1004 → BUS_UPGR issued; after bus_done, state M written; cpu_rsp hit=1.
- cpu_req_valid and snp_valid both high in IDLE → cpu_req_ready=0 and snoop accepted; CPU accepted on the first IDLE cycle after the snoop response.
- CPU read 0x0010_1004 (index 0x001, victim M) → BUS_RD with bus_req_wb=1. Assert rst during BUS_WAIT → bus_req_valid=0 next cycle; no ta_write_en or cpu_rsp ever.
